// File: rtl/alu_display_pkg.sv
// Shared definitions for the ALU result -> seven-segment display path.
package alu_display_pkg;

    // Converter sequencing: wait for a request, run the shift-add-3 loop,
    // then publish the result for one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    // Nibble the display decodes as an unlit digit.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Largest magnitude the four-digit display can show.
    localparam int DISP_LIMIT = 9999;

    // Bits per BCD digit.
    localparam int DIGIT_W = 4;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import alu_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Add 3 when the digit would become >= 10 after doubling.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/alu_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble) feeding the display mux.
// One bit is processed per cycle; results are held until the next conversion.
// Optional feature: define ALU_BCD_SIGNED_EN to treat in_data as two's
// complement and report the sign on 'negative'; otherwise 'negative' is 0.
module alu_bin_to_bcd
    import alu_display_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BCD_DIGITS = 5,
    parameter int OUT_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [DIGIT_W*OUT_DIGITS-1:0] bcd_out,
    output logic                          bcd_valid,
    output logic                          done,
    output logic                          overflow,
    output logic                          negative
);

    localparam int BCD_W    = BCD_DIGITS * DIGIT_W;
    localparam int OUT_W    = OUT_DIGITS * DIGIT_W;
    localparam int SR_W     = BCD_W + DATA_W;
    localparam int CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    bcd_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    sr_d;
    logic               in_ready_q;
    logic [OUT_W-1:0]   bcd_q;
    logic               valid_q;
    logic               done_q;
    logic               ovf_q;
    logic [DATA_W-1:0]  mag;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   fin_digits;
    logic               fin_ovf;

`ifdef ALU_BCD_SIGNED_EN
    logic sign_q;
    logic neg_q;

    // Magnitude of a two's-complement input; 0x8000 maps to 32768.
    always_comb begin
        mag = in_data;
        if (in_data[DATA_W-1]) begin
            mag = ~in_data + 1'b1;
        end
    end
`else
    // Unsigned mode: the input already is the magnitude.
    always_comb begin
        mag = in_data;
    end
`endif

    // One correction unit per internal BCD digit of the shift register.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (sr_q[DATA_W + g*DIGIT_W +: DIGIT_W]),
            .digit_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // One double-dabble iteration: corrected digits, then shift left by one.
    always_comb begin
        sr_d       = {adj[BCD_W-2:0], sr_q[DATA_W-1:0], 1'b0};
        fin_digits = sr_d[SR_W-1 -: BCD_W];
        fin_ovf    = |fin_digits[BCD_W-1:OUT_W];
    end

    // Control FSM plus datapath; outputs only change on the last shift so the
    // display never sees intermediate values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            in_ready_q <= 1'b1;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef ALU_BCD_SIGNED_EN
            sign_q     <= 1'b0;
            neg_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q       <= {{BCD_W{1'b0}}, mag};
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
`ifdef ALU_BCD_SIGNED_EN
                        sign_q     <= in_data[DATA_W-1];
`endif
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Publish straight from the final iteration so the
                        // new value and the done pulse appear together.
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        ovf_q   <= fin_ovf;
                        bcd_q   <= fin_ovf ? {OUT_DIGITS{BCD_BLANK}}
                                           : fin_digits[OUT_W-1:0];
`ifdef ALU_BCD_SIGNED_EN
                        neg_q   <= sign_q;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign bcd_out   = bcd_q;
    assign bcd_valid = valid_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
`ifdef ALU_BCD_SIGNED_EN
    assign negative  = neg_q;
`else
    assign negative  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bin_to_bcd.sv
// Directed bench for alu_bin_to_bcd: vector table plus busy, reset and hold
// sequences. Expectations follow ALU_BCD_SIGNED_EN when it is defined.
module tb_alu_bin_to_bcd;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic        done;
    logic        overflow;
    logic        negative;

    int total;
    int bad;
    int done_cnt;

    alu_bin_to_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .done      (done),
        .overflow  (overflow),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [15:0] din;
        logic [15:0] bcd;
        logic        ovf;
        logic        neg;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle 18.
    task automatic conv(input logic [15:0] d, output logic [15:0] b, output logic ov,
                        output logic ng, output int lat, output logic rdy_dropped);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid    = 1'b0;
        rdy_dropped = !in_ready;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        b  = bcd_out;
        ov = overflow;
        ng = negative;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] b;
        logic        ov, ng, rd;
        int          lat, d0, hold_bad, c;

        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0;

`ifdef ALU_BCD_SIGNED_EN
        vecs[0] = '{16'h04D2, 16'h1234, 1'b0, 1'b0};
        vecs[1] = '{16'h270F, 16'h9999, 1'b0, 1'b0};
        vecs[2] = '{16'h2710, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFD6, 16'h0042, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b1, 1'b1};
        vecs[7] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1};
        vecs[8] = '{16'hD8F1, 16'h9999, 1'b0, 1'b1};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0};
`else
        vecs[0] = '{16'h04D2, 16'h1234, 1'b0, 1'b0};
        vecs[1] = '{16'h270F, 16'h9999, 1'b0, 1'b0};
        vecs[2] = '{16'h2710, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFD6, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{16'hD8F1, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_bcd", bcd_out, 0);
        chk("rst_valid", bcd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_neg", negative, 0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            conv(vecs[i].din, b, ov, ng, lat, rd);
            chk($sformatf("v%0d_bcd", i), b, vecs[i].bcd);
            chk($sformatf("v%0d_ovf", i), ov, vecs[i].ovf);
            chk($sformatf("v%0d_neg", i), ng, vecs[i].neg);
            chk($sformatf("v%0d_lat", i), lat, 17);
            chk($sformatf("v%0d_rdy_drop", i), rd, 1);
            chk($sformatf("v%0d_rdy_back", i), in_ready, 1);
            chk($sformatf("v%0d_valid", i), bcd_valid, 1);
            chk($sformatf("v%0d_done_low", i), done, 0);
        end

        // Busy rejection: requests while converting are ignored, in_data
        // changes do not disturb the running conversion.
        in_valid = 1'b1;
        in_data  = 16'h0007;
        @(negedge clk);
        d0 = done_cnt;
        for (c = 1; c <= 16; c++) begin
            in_valid = 1'b1;
            in_data  = (c % 2 == 1 && c != 16) ? 16'h2222 : 16'h1111;
            @(negedge clk);
        end
        chk("busy_done_c17", done, 1);
        chk("busy_bcd", bcd_out, 16'h0007);
        chk("busy_ready_c17", in_ready, 0);
        @(negedge clk);
        chk("busy_ready_c18", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_one_pulse", done_cnt - d0, 1);
        chk("busy_req_taken", in_ready, 0);
        lat = 19;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_second_lat", lat, 35);
        chk("busy_second_bcd", bcd_out, 16'h4369);
        @(negedge clk);

        // Reset mid-conversion
        conv(16'h04D2, b, ov, ng, lat, rd);
        chk("rmid_pre_bcd", b, 16'h1234);
        in_valid = 1'b1;
        in_data  = 16'h0058;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("rmid_bcd", bcd_out, 0);
        chk("rmid_valid", bcd_valid, 0);
        chk("rmid_done", done, 0);
        chk("rmid_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("rmid_no_pulse", done_cnt - d0, 0);
        chk("rmid_bcd_held", bcd_out, 0);
        conv(16'h0058, b, ov, ng, lat, rd);
        chk("rmid_after_bcd", b, 16'h0088);
        chk("rmid_after_lat", lat, 17);

        // Hold stability
        conv(16'h0100, b, ov, ng, lat, rd);
        chk("hold_first", b, 16'h0256);
        hold_bad = 0;
        for (int k = 0; k < 1000; k++) begin
            in_data = 16'($urandom);
            @(negedge clk);
            if (bcd_out !== 16'h0256 || done !== 1'b0) hold_bad++;
        end
        chk("hold_stable", hold_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
